// File: rtl/instr_buffer_pkg.sv
// Shared types and constants for the instruction buffer controller.
package instr_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Address width for a buffer of n words; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/instr_ram.sv
// Simple dual-port instruction store: one synchronous write port and one
// registered read port. No reset, so it maps onto block RAM.
module instr_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int W     = 32
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge CLK) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_buffer_ctrl.sv
// Program-load and run-control stage in front of the SIMD core: fills the
// instruction buffer from the PS stream, serves core fetches, and sequences
// START/STOP while counting run cycles.
//
// state | meaning
// IDLE  | buffer empty, accepting words
// LOAD  | at least one word stored, waiting for the last one
// READY | program complete, waiting for go
// RUN   | core running, cycle counter advancing
// DONE  | core stopped, cycle count frozen, go re-runs
module instr_buffer_ctrl
  import instr_buffer_pkg::*;
#(
  parameter int N = 512,
  parameter int W = 32
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [W-1:0]           wr_data,
  input  logic                   wr_last,
  input  logic                   go,
  input  logic                   clear,
  input  logic [addr_width(N)-1:0] PC_AXI,
  output logic [W-1:0]           INSTR_AXI,
  output logic                   START_SIGNAL,
  input  logic                   STOP_SIGNAL,
  output logic                   busy,
  output logic                   done,
  output logic [addr_width(N):0] instr_count,
  output logic [31:0]            cycle_count,
  output logic                   err_overflow
);

  localparam int AW = addr_width(N);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(N);

  state_t       state_q;
  state_t       state_d;
  logic         wr_fire;
  logic         fill_word;
  logic         clear_accept;
  logic         go_accept;
  logic         in_range_q;
  logic [W-1:0] ram_rdata;

  assign wr_fire      = wr_valid && wr_ready;
  // This transfer occupies the last free slot.
  assign fill_word    = (instr_count == FULL_COUNT - CW'(1));
  assign clear_accept = clear && (state_q != RUN);
  assign go_accept    = go && !clear_accept && ((state_q == READY) || (state_q == DONE));

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // Next-state decode; clear outranks go and load transfers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!clear && wr_fire) begin
          state_d = (wr_last || fill_word) ? READY : LOAD;
        end
      end
      LOAD: begin
        if (clear) begin
          state_d = IDLE;
        end else if (wr_fire && (wr_last || fill_word)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (clear) begin
          state_d = IDLE;
        end else if (go) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (STOP_SIGNAL) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (clear) begin
          state_d = IDLE;
        end else if (go) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, handshake, start pulse and the status counters.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      wr_ready     <= 1'b0;
      START_SIGNAL <= 1'b0;
      instr_count  <= '0;
      cycle_count  <= '0;
      err_overflow <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ready     <= (state_d == IDLE) || (state_d == LOAD);
      START_SIGNAL <= go_accept;
      if (clear_accept) begin
        instr_count  <= '0;
        cycle_count  <= '0;
        err_overflow <= 1'b0;
      end else begin
        if (wr_fire) begin
          instr_count <= instr_count + CW'(1);
          if (fill_word && !wr_last) begin
            err_overflow <= 1'b1;
          end
        end
        if (go_accept) begin
          cycle_count <= '0;
        end else if ((state_q == RUN) && (cycle_count != 32'hFFFF_FFFF)) begin
          cycle_count <= cycle_count + 32'd1;
        end
      end
    end
  end

  // Range flag travels alongside the RAM read so out-of-range fetches see NOP.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      in_range_q <= 1'b0;
    end else begin
      in_range_q <= ({1'b0, PC_AXI} < instr_count);
    end
  end

  assign INSTR_AXI = in_range_q ? ram_rdata : W'(NOP_INSTR);

  instr_ram #(
    .DEPTH (N),
    .AW    (AW),
    .W     (W)
  ) u_ram (
    .CLK   (CLK),
    .we    (wr_fire && !clear),
    .waddr (instr_count[AW-1:0]),
    .wdata (wr_data),
    .raddr (PC_AXI),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_instr_buffer_ctrl.sv
// Directed and randomized bench for instr_buffer_ctrl against a
// program-level reference model (word list, completion and error flags).
module tb_instr_buffer_ctrl;

  localparam int N  = 512;
  localparam int W  = 32;
  localparam int AW = $clog2(N);

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_last = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          go = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] PC_AXI = '0;
  logic          STOP_SIGNAL = 1'b0;
  logic          wr_ready;
  logic [W-1:0]  INSTR_AXI;
  logic          START_SIGNAL;
  logic          busy;
  logic          done;
  logic [AW:0]   instr_count;
  logic [31:0]   cycle_count;
  logic          err_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: program contents and load status.
  logic [W-1:0] mem_m [N];
  int           m_count = 0;
  bit           m_complete = 1'b0;
  bit           m_err = 1'b0;

  instr_buffer_ctrl #(.N(N), .W(W)) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .go           (go),
    .clear        (clear),
    .PC_AXI       (PC_AXI),
    .INSTR_AXI    (INSTR_AXI),
    .START_SIGNAL (START_SIGNAL),
    .STOP_SIGNAL  (STOP_SIGNAL),
    .busy         (busy),
    .done         (done),
    .instr_count  (instr_count),
    .cycle_count  (cycle_count),
    .err_overflow (err_overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [W-1:0] model_fetch(input int a);
    return (a < m_count) ? mem_m[a] : '0;
  endfunction

  task automatic model_clear();
    m_count    = 0;
    m_complete = 1'b0;
    m_err      = 1'b0;
  endtask

  // Offer one word for one cycle; the model decides whether it is taken.
  task automatic push(input logic [W-1:0] d, input bit last);
    bit acc;
    acc      = !m_complete && (m_count < N);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    check("wr_ready", wr_ready, acc);
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    if (acc) begin
      mem_m[m_count] = d;
      m_count++;
      if ((m_count == N) && !last) m_err = 1'b1;
      if (last || (m_count == N)) m_complete = 1'b1;
    end
    check("instr_count", instr_count, m_count);
  endtask

  task automatic fetch_chk(input int a, input string tag);
    PC_AXI = a[AW-1:0];
    tick();
    check(tag, INSTR_AXI, model_fetch(a));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    check("clear_count", instr_count, 0);
    check("clear_err", err_overflow, 0);
    check("clear_cycles", cycle_count, 0);
    check("clear_wr_ready", wr_ready, 1);
  endtask

  // Run with STOP low for 'low' RUN cycles, then high: expect low+1 cycles.
  task automatic run_prog(input int low);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("start_pulse", START_SIGNAL, 1);
    check("run_busy", busy, 1);
    check("run_cycles0", cycle_count, 0);
    for (int i = 0; i < low; i++) begin
      tick();
      if (i == 0) check("start_single", START_SIGNAL, 0);
      check("run_cycles", cycle_count, i + 1);
    end
    STOP_SIGNAL = 1'b1;
    tick();
    STOP_SIGNAL = 1'b0;
    check("done_flag", done, 1);
    check("done_busy", busy, 0);
    check("done_start", START_SIGNAL, 0);
    check("done_cycles", cycle_count, low + 1);
    tick();
    check("frozen_cycles", cycle_count, low + 1);
  endtask

  initial begin
    int len;
    int a;

    // Reset state
    RSTN = 1'b0;
    tick();
    tick();
    check("rst_wr_ready", wr_ready, 0);
    check("rst_instr", INSTR_AXI, 0);
    check("rst_start", START_SIGNAL, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", instr_count, 0);
    check("rst_cycles", cycle_count, 0);
    check("rst_err", err_overflow, 0);
    RSTN = 1'b1;
    model_clear();
    tick();
    check("post_rst_wr_ready", wr_ready, 1);

    // Four-word program
    push(32'h11, 1'b0);
    push(32'h22, 1'b0);
    push(32'h33, 1'b0);
    push(32'h44, 1'b1);
    check("ready_wr_ready", wr_ready, 0);
    check("ready_count", instr_count, 4);
    fetch_chk(2, "fetch_2");
    check("fetch_2_value", INSTR_AXI, 32'h33);
    fetch_chk(7, "fetch_7");
    fetch_chk(3, "fetch_3");
    fetch_chk(4, "fetch_4_edge");

    // Runs: directed length, random length, STOP during the START cycle
    run_prog(10);
    run_prog($urandom_range(0, 20));
    run_prog(0);

    // clear and go together in DONE
    clear = 1'b1;
    go    = 1'b1;
    tick();
    clear = 1'b0;
    go    = 1'b0;
    model_clear();
    check("cg_count", instr_count, 0);
    check("cg_done", done, 0);
    check("cg_busy", busy, 0);
    check("cg_start", START_SIGNAL, 0);
    check("cg_wr_ready", wr_ready, 1);

    // go in IDLE is ignored
    go = 1'b1;
    tick();
    go = 1'b0;
    check("idle_go_busy", busy, 0);
    check("idle_go_start", START_SIGNAL, 0);
    fetch_chk(0, "idle_fetch");

    // clear during RUN is ignored
    push($urandom, 1'b0);
    push($urandom, 1'b0);
    push($urandom, 1'b1);
    go = 1'b1;
    tick();
    go = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("run_clear_busy", busy, 1);
    check("run_clear_count", instr_count, m_count);
    tick();
    STOP_SIGNAL = 1'b1;
    tick();
    STOP_SIGNAL = 1'b0;
    check("run_clear_done", done, 1);
    check("run_clear_cycles", cycle_count, 3);
    fetch_chk(1, "run_clear_fetch");

    // Overflow: fill all N words without last
    do_clear();
    for (int k = 0; k < N; k++) push($urandom, 1'b0);
    check("ovf_err", err_overflow, 1);
    check("ovf_wr_ready", wr_ready, 0);
    check("ovf_count", instr_count, N);
    push(32'hDEAD_BEEF, 1'b1);
    fetch_chk(0, "ovf_fetch_first");
    fetch_chk(N - 1, "ovf_fetch_last");
    for (int k = 0; k < 4; k++) fetch_chk($urandom_range(0, N - 1), "ovf_fetch_rand");
    do_clear();

    // Reset in the middle of RUN
    push($urandom, 1'b0);
    push($urandom, 1'b1);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    RSTN = 1'b0;
    tick();
    check("mid_rst_start", START_SIGNAL, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_count", instr_count, 0);
    check("mid_rst_cycles", cycle_count, 0);
    check("mid_rst_err", err_overflow, 0);
    check("mid_rst_instr", INSTR_AXI, 0);
    check("mid_rst_wr_ready", wr_ready, 0);
    RSTN = 1'b1;
    model_clear();
    tick();
    check("mid_rst_release_ready", wr_ready, 1);
    fetch_chk(0, "mid_rst_fetch0");

    // Randomized gapped loads, scoreboarded through fetches
    for (int r = 0; r < 6; r++) begin
      do_clear();
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        push($urandom, k == len - 1);
      end
      push($urandom, 1'b0);
      for (int k = 0; k <= len; k++) fetch_chk(k, "rand_fetch");
      a = $urandom_range(0, N - 1);
      fetch_chk(a, "rand_fetch_any");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_buffer_ctrl.md
# instr_buffer_ctrl

Program-load and run-control stage directly upstream of the SIMD core wrapper. Accepts a stream of 32-bit instruction words from the PS side into an N-entry on-chip instruction buffer, then serves them to the core through the `PC_AXI` / `INSTR_AXI` fetch pair. Issues the core's `START_SIGNAL`, watches `STOP_SIGNAL`, and reports run status and cycle count back to the PS.

## Interface
Parameters:
- `N`, 512, instruction buffer depth in words; must match the core's `N`.
- `W`, 32, instruction width.

Ports:
- `CLK`  in  1  sole clock; all logic on the rising edge.
- `RSTN`  in  1  synchronous, active-low reset.
- `wr_valid`  in  1  load-stream word valid.
- `wr_ready`  out  1  load-stream ready.
- `wr_data`  in  W  instruction word.
- `wr_last`  in  1  marks the final word of a program.
- `go`  in  1  single-cycle run request from the PS.
- `clear`  in  1  single-cycle request to discard the program and return to empty.
- `PC_AXI`  in  $clog2(N)  fetch address from the core.
- `INSTR_AXI`  out  W  fetched instruction to the core.
- `START_SIGNAL`  out  1  one-cycle start pulse to the core.
- `STOP_SIGNAL`  in  1  core finished.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `instr_count`  out  $clog2(N)+1  number of words loaded.
- `cycle_count`  out  32  cycles spent in the last or current RUN.
- `err_overflow`  out  1  sticky; buffer filled without `wr_last`.

## Operation
- States: IDLE (empty), LOAD (≥1 word, no last yet), READY (program complete), RUN, DONE.
- Handshake: a word transfers when `wr_valid && wr_ready`. The word is written to `mem[instr_count]`, and `instr_count` then increments.
- `wr_ready = 1` in IDLE and LOAD only. It is driven from registered state, with no combinational path from `wr_valid`.
- IDLE → LOAD on the first transfer. If that first word carries `wr_last`, IDLE → READY instead.
- LOAD → READY on a transfer with `wr_last`.
- Full buffer: the transfer that makes `instr_count == N` forces → READY. If that word lacked `wr_last`, set `err_overflow`.
- READY + `go` → RUN: `START_SIGNAL` is high for exactly the first RUN cycle, and `cycle_count` clears to 0.
- RUN:
  - `cycle_count` increments every cycle and saturates at 0xFFFFFFFF.
  - `STOP_SIGNAL` is sampled only in RUN; when high → DONE, and `cycle_count` freezes.
- DONE + `go` → RUN: re-runs the same program, with a fresh `START_SIGNAL` pulse and a cleared `cycle_count`.
- `go` in IDLE, LOAD or RUN is ignored.
- `clear` in any state except RUN → IDLE. It zeroes `instr_count`, `cycle_count` and `err_overflow`. Buffer contents are not erased.
- `clear` during RUN is ignored; the core must be stopped first.
- If `clear` and `go` arrive in the same cycle, `clear` wins.
- Fetch: `INSTR_AXI` returns `mem[PC_AXI]` if `PC_AXI < instr_count`, otherwise 0x00000000 (NOP). Fetch is valid in every state.

## Timing
- Reset (`RSTN` low at a clock edge) forces:
  - state IDLE; `wr_ready` 0 during reset, 1 from the first cycle after;
  - `INSTR_AXI` 0, `START_SIGNAL` 0, `busy` 0, `done` 0;
  - `instr_count` 0, `cycle_count` 0, `err_overflow` 0.
- Memory is not reset. Since `instr_count` is 0 after reset, every fetch returns 0.
- Reset mid-RUN aborts immediately, with no `START_SIGNAL` and no `done`.
- Fetch latency is 1 cycle: `INSTR_AXI` at edge t+1 reflects `PC_AXI` and `instr_count` sampled at edge t.
- A word written at edge t is readable by a fetch presented in cycle t+1 (`INSTR_AXI` valid at t+2).
- `go` sampled at edge t in READY: `START_SIGNAL` and `busy` are high in cycle t+1.
- `STOP_SIGNAL` sampled high at edge t in RUN: `busy` goes 0 and `done` goes 1 in cycle t+1.
- `STOP_SIGNAL` high in the same cycle as the `START_SIGNAL` pulse is honoured.
- `cycle_count` equals the number of RUN cycles, counting the `START_SIGNAL` cycle.

## Structure
- Package `instr_buffer_pkg`: state enum (IDLE, LOAD, READY, RUN, DONE), `NOP_INSTR = 32'h0`, and the width function `$clog2(N)`.
- Sub-module `instr_ram`: simple dual-port RAM, one synchronous write port, one registered read port, no reset, BRAM-inferable.
- NOP substitution uses a registered `in_range` flag that muxes the RAM output.

## Test plan
- Reset, then load 4 words 0x11,0x22,0x33,0x44 with `wr_last` on the 4th → state READY, `instr_count` = 4, `wr_ready` = 0; `PC_AXI` = 2 gives `INSTR_AXI` = 0x33 one cycle later; `PC_AXI` = 7 gives 0.
- `go` in READY → `START_SIGNAL` single-cycle pulse. Hold `STOP_SIGNAL` low 10 cycles, then high → `done` = 1, `cycle_count` = 11; a second `go` produces a new pulse and `cycle_count` restarts from 1.
- Stream 512 words with no `wr_last` → READY after the 512th, `err_overflow` = 1, `wr_ready` = 0; a 513th `wr_valid` is not accepted.
- `go` in IDLE and `clear` during RUN → both ignored. `clear` and `go` together in DONE → IDLE, `instr_count` = 0.
- Assert `RSTN` low mid-RUN → all outputs 0 next cycle, `wr_ready` = 1 the cycle after release, and fetch of `PC_AXI` = 0 returns 0.
- Random `wr_valid` with back-to-back and gapped words → scoreboard every stored word against fetches at all addresses below `instr_count`.
